// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot/debug controller:
// word width, default address width and the controller state type.
package imem_boot_ctrl_pkg;

    localparam int DEFAULT_PC_WIDTH = 8;
    localparam int WORD_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DBG_ADDR,
        ST_DBG_DATA
    } state_t;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot loader and debug-read arbiter for the instruction memory port: streams an
// image into memory while the core is held in reset, then shares reads with fetch.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                boot_skip,
    input  logic                reload,
    input  logic                ld_valid,
    input  logic [WORD_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    input  logic                dbg_req,
    input  logic [PC_WIDTH-1:0] dbg_addr,
    output logic                dbg_ack,
    output logic [WORD_W-1:0]   dbg_rdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                mem_addr_sel,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_we,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                core_rst,
    output logic                fetch_en,
    output logic [PC_WIDTH:0]   load_count,
    output logic                load_err
);

    localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PC_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [PC_WIDTH:0]   COUNT_ONE = 1;

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH-1:0]   wr_ptr;
    logic [WORD_W-1:0]     dbg_rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            load_count  <= '0;
            load_err    <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_ptr     <= '0;
                    load_count <= '0;
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        load_count <= load_count + COUNT_ONE;
                        // The pointer saturates on the last address rather than wrapping.
                        if (wr_ptr != LAST_ADDR) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end else if (!ld_last) begin
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        wr_ptr     <= '0;
                        load_count <= '0;
                        load_err   <= 1'b0;
                    end
                end
                ST_DBG_DATA: begin
                    dbg_rdata_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state_next is assigned a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     state_next = boot_skip ? ST_START : ST_LOAD;
            ST_LOAD: begin
                if (ld_valid && (ld_last || wr_ptr == LAST_ADDR)) begin
                    state_next = ST_START;
                end
            end
            ST_START:    state_next = ST_RUN;
            ST_RUN: begin
                if (reload) begin
                    state_next = ST_LOAD;
                end else if (dbg_req) begin
                    state_next = ST_DBG_ADDR;
                end
            end
            ST_DBG_ADDR: state_next = ST_DBG_DATA;
            ST_DBG_DATA: state_next = ST_RUN;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b1;
        mem_addr     = '0;
        mem_wdata    = '0;
        core_rst     = 1'b1;
        fetch_en     = 1'b0;
        dbg_ack      = 1'b0;
        dbg_rdata    = dbg_rdata_q;
        case (state)
            ST_LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_addr  = wr_ptr;
                mem_wdata = ld_data;
            end
            ST_RUN: begin
                core_rst     = 1'b0;
                fetch_en     = 1'b1;
                mem_addr_sel = 1'b0;
            end
            ST_DBG_ADDR: begin
                core_rst = 1'b0;
                mem_addr = dbg_addr;
            end
            ST_DBG_DATA: begin
                // Memory output is already a register; forward it so data and ack coincide.
                core_rst     = 1'b0;
                mem_addr_sel = 1'b0;
                dbg_ack      = 1'b1;
                dbg_rdata    = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
